class_score_argmax: RTL

//  Downstream of full_system_top: consumes the packed class_scores vector on its valid_out pulse.

---
 rtl/class_score_argmax_if.sv | 49 ++++
 rtl/class_score_argmax.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/class_score_argmax_if.sv
// Result/score handshake bundle for class_score_argmax.
// The second_idx/second_score/margin signals exist only when ARGMAX_TOP2_EN is defined.
interface class_score_argmax_if #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned NUM_CLASSES = 15,
  parameter int unsigned IDX_W       = $clog2(NUM_CLASSES)
);
  logic [NUM_CLASSES*DATA_WIDTH-1:0] scores_in;
  logic                              scores_valid;
  logic                              scores_ready;
  logic                              result_valid;
  logic                              result_ready;
  logic [IDX_W-1:0]                  class_idx;
  logic signed [DATA_WIDTH-1:0]      class_score;
  logic                              low_conf;
  logic                              busy;
  logic                              overrun;
`ifdef ARGMAX_TOP2_EN
  logic [IDX_W-1:0]                  second_idx;
  logic signed [DATA_WIDTH-1:0]      second_score;
  logic [DATA_WIDTH:0]               margin;

  // Upstream producer plus result consumer.
  modport master (
    output scores_in, scores_valid, result_ready,
    input  scores_ready, result_valid, class_idx, class_score, low_conf, busy, overrun,
    input  second_idx, second_score, margin
  );

  // The argmax engine.
  modport slave (
    input  scores_in, scores_valid, result_ready,
    output scores_ready, result_valid, class_idx, class_score, low_conf, busy, overrun,
    output second_idx, second_score, margin
  );
`else
  // Upstream producer plus result consumer.
  modport master (
    output scores_in, scores_valid, result_ready,
    input  scores_ready, result_valid, class_idx, class_score, low_conf, busy, overrun
  );

  // The argmax engine.
  modport slave (
    input  scores_in, scores_valid, result_ready,
    output scores_ready, result_valid, class_idx, class_score, low_conf, busy, overrun
  );
`endif
endinterface

// File: rtl/class_score_argmax.sv
// Sequential argmax over a packed vector of signed class scores.
// Captures the vector on a one-cycle pulse, scans one class per clock and holds the
// result behind a valid/ready handshake. Define ARGMAX_TOP2_EN to also track the
// runner-up class and the best-minus-second margin.
module class_score_argmax #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned NUM_CLASSES = 15,
  parameter int unsigned IDX_W       = $clog2(NUM_CLASSES),
  parameter logic signed [DATA_WIDTH-1:0] CONF_THRESH = 16'sd256
) (
  input logic                 clk,
  input logic                 rst,
  class_score_argmax_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_CLASSES - 1);
  localparam logic signed [DATA_WIDTH-1:0] MinScore = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  state_e                       state_q;
  logic signed [DATA_WIDTH-1:0] vec_q [NUM_CLASSES];
  logic [IDX_W-1:0]             cnt_q;
  logic signed [DATA_WIDTH-1:0] best_q;
  logic [IDX_W-1:0]             best_idx_q;
  logic                         result_valid_q;
  logic [IDX_W-1:0]             class_idx_q;
  logic signed [DATA_WIDTH-1:0] class_score_q;
  logic                         low_conf_q;
  logic                         overrun_q;

  logic                         scores_ready;
  logic                         accept;
  logic                         last;
  logic signed [DATA_WIDTH-1:0] cand;
  logic signed [DATA_WIDTH-1:0] best_nxt;
  logic [IDX_W-1:0]             best_idx_nxt;

`ifdef ARGMAX_TOP2_EN
  logic signed [DATA_WIDTH-1:0] second_q;
  logic [IDX_W-1:0]             second_idx_q;
  logic signed [DATA_WIDTH-1:0] second_score_q;
  logic [IDX_W-1:0]             second_out_idx_q;
  logic [DATA_WIDTH:0]          margin_q;
  logic signed [DATA_WIDTH-1:0] second_nxt;
  logic [IDX_W-1:0]             second_idx_nxt;
`endif

  assign scores_ready = (state_q == StIdle) || ((state_q == StDone) && bus.result_ready);
  assign accept       = bus.scores_valid && scores_ready;
  assign last         = (cnt_q == LastIdx);
  assign cand         = vec_q[cnt_q];

  // Running best (and runner-up) after folding in the class at index cnt_q.
  always_comb begin
    best_nxt     = best_q;
    best_idx_nxt = best_idx_q;
`ifdef ARGMAX_TOP2_EN
    second_nxt     = second_q;
    second_idx_nxt = second_idx_q;
`endif
    // Strictly greater only, so ties keep the lower index.
    if (cand > best_q) begin
      best_nxt     = cand;
      best_idx_nxt = cnt_q;
`ifdef ARGMAX_TOP2_EN
      second_nxt     = best_q;
      second_idx_nxt = best_idx_q;
    end else if (cand > second_q) begin
      second_nxt     = cand;
      second_idx_nxt = cnt_q;
`endif
    end
  end

  // FSM, scan datapath and registered result outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= StIdle;
      for (int i = 0; i < int'(NUM_CLASSES); i++) vec_q[i] <= '0;
      cnt_q          <= '0;
      best_q         <= '0;
      best_idx_q     <= '0;
      result_valid_q <= 1'b0;
      class_idx_q    <= '0;
      class_score_q  <= '0;
      low_conf_q     <= 1'b0;
      overrun_q      <= 1'b0;
`ifdef ARGMAX_TOP2_EN
      second_q         <= '0;
      second_idx_q     <= '0;
      second_score_q   <= '0;
      second_out_idx_q <= '0;
      margin_q         <= '0;
`endif
    end else begin
      // Upstream cannot stall, so a pulse we cannot take is lost; remember that it happened.
      if (bus.scores_valid && !scores_ready) overrun_q <= 1'b1;

      unique case (state_q)
        StIdle: begin
          if (accept) state_q <= StScan;
        end
        StScan: begin
          best_q     <= best_nxt;
          best_idx_q <= best_idx_nxt;
`ifdef ARGMAX_TOP2_EN
          second_q     <= second_nxt;
          second_idx_q <= second_idx_nxt;
`endif
          if (last) begin
            state_q        <= StDone;
            result_valid_q <= 1'b1;
            class_idx_q    <= best_idx_nxt;
            class_score_q  <= best_nxt;
            low_conf_q     <= (best_nxt < CONF_THRESH);
`ifdef ARGMAX_TOP2_EN
            second_score_q   <= second_nxt;
            second_out_idx_q <= second_idx_nxt;
            margin_q         <= {best_nxt[DATA_WIDTH-1], best_nxt}
                              - {second_nxt[DATA_WIDTH-1], second_nxt};
`endif
          end else begin
            cnt_q <= cnt_q + IDX_W'(1);
          end
        end
        StDone: begin
          if (bus.result_ready) begin
            result_valid_q <= 1'b0;
            state_q        <= accept ? StScan : StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase

      // Capture a new vector; class 0 seeds the scan.
      if (accept) begin
        for (int i = 0; i < int'(NUM_CLASSES); i++) begin
          vec_q[i] <= bus.scores_in[i*DATA_WIDTH +: DATA_WIDTH];
        end
        best_q     <= bus.scores_in[DATA_WIDTH-1:0];
        best_idx_q <= '0;
        cnt_q      <= IDX_W'(1);
`ifdef ARGMAX_TOP2_EN
        second_q     <= MinScore;
        second_idx_q <= IDX_W'(1);
`endif
      end
    end
  end

  assign bus.scores_ready = scores_ready;
  assign bus.result_valid = result_valid_q;
  assign bus.class_idx    = class_idx_q;
  assign bus.class_score  = class_score_q;
  assign bus.low_conf     = low_conf_q;
  assign bus.busy         = (state_q != StIdle);
  assign bus.overrun      = overrun_q;
`ifdef ARGMAX_TOP2_EN
  assign bus.second_idx   = second_out_idx_q;
  assign bus.second_score = second_score_q;
  assign bus.margin       = margin_q;
`endif

endmodule
